// File: rtl/cpu_pkg.sv
// Shared CPU package: default datapath widths, the NOP encoding and the
// instruction-fetch FSM state encoding used by the fetch stage and its
// hold buffer.
package cpu_pkg;

    // Default program-counter / program-memory address width.
    localparam int CPU_PC_WIDTH = 14;

    // Default instruction-word width.
    localparam int CPU_INSTR_WIDTH = 32;

    // Bubble word presented whenever no real instruction is available.
    localparam logic [31:0] CPU_NOP = 32'h0000_0000;

    // Fetch FSM states.
    typedef enum logic [1:0] {
        FETCH_IDLE = 2'b00,
        FETCH_RUN  = 2'b01,
        FETCH_HOLD = 2'b10
    } fetch_state_e;

endpackage : cpu_pkg

// File: rtl/fetch_hold_buffer.sv
// Hold buffer for the instruction-fetch stage.
// Captures the word presented to the fetch/decode register when the pipeline
// stalls and replays it until the stall is released. The output mux selects
// between the captured copy and the live fetch path.
//
// Ports:
//   clock, reset   - clock and synchronous active-high reset
//   capture        - load the live word/return address/target flag
//   clear          - discard the held contents (redirect)
//   use_hold       - present the held copy instead of the live path
//   live_word/ret/tgt - live fetch path (already bubbled when invalid)
//   word_out/ret_out/tgt_out - selected values towards the pipeline register
module fetch_hold_buffer
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH    = CPU_PC_WIDTH,
    parameter int INSTR_WIDTH = CPU_INSTR_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   capture,
    input  logic                   clear,
    input  logic                   use_hold,
    input  logic [INSTR_WIDTH-1:0] live_word,
    input  logic [PC_WIDTH-1:0]    live_ret,
    input  logic                   live_tgt,
    output logic [INSTR_WIDTH-1:0] word_out,
    output logic [PC_WIDTH-1:0]    ret_out,
    output logic                   tgt_out
);

    logic [INSTR_WIDTH-1:0] hold_word_r;
    logic [PC_WIDTH-1:0]    hold_ret_r;
    logic                   hold_tgt_r;

    // Hold registers: reset and clear win over capture so a redirect in the
    // same cycle as a stall leaves nothing stale behind.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            hold_word_r <= {INSTR_WIDTH{1'b0}};
            hold_ret_r  <= {PC_WIDTH{1'b0}};
            hold_tgt_r  <= 1'b0;
        end else if (capture) begin
            hold_word_r <= live_word;
            hold_ret_r  <= live_ret;
            hold_tgt_r  <= live_tgt;
        end else begin
            hold_word_r <= hold_word_r;
            hold_ret_r  <= hold_ret_r;
            hold_tgt_r  <= hold_tgt_r;
        end
    end

    // Output selection between the held copy and the live fetch path.
    always_comb begin
        word_out = live_word;
        ret_out  = live_ret;
        tgt_out  = live_tgt;
        if (use_hold) begin
            word_out = hold_word_r;
            ret_out  = hold_ret_r;
            tgt_out  = hold_tgt_r;
        end else begin
            word_out = live_word;
            ret_out  = live_ret;
            tgt_out  = live_tgt;
        end
    end

endmodule : fetch_hold_buffer

// File: rtl/instruction_fetch.sv
// Instruction-fetch stage.
// Owns the program counter and the IDLE/RUN/HOLD fetch FSM, issues
// program-memory reads, and presents the returned word (one cycle after the
// read) to the fetch/decode pipeline register. Stalls replay the current
// word from fetch_hold_buffer; redirects read the target in the same cycle.
//
// Ports:
//   clock, reset          - clock and synchronous active-high reset
//   stall                 - downstream register is holding this cycle
//   take_branch_addr      - redirect request, target on branch_addr
//   pmem_addr, pmem_rd_en - program-memory read address and strobe
//   pmem_data             - read data, valid one cycle after pmem_rd_en
//   instruction_out       - fetched word (NOP when no word is available)
//   return_addr_out       - address of instruction_out plus one
//   take_branch_addr_out  - instruction_out is the first word at a target
//   fetch_valid           - instruction_out is a real instruction
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH    = CPU_PC_WIDTH,
    parameter int INSTR_WIDTH = CPU_INSTR_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   take_branch_addr,
    input  logic [PC_WIDTH-1:0]    branch_addr,
    output logic [PC_WIDTH-1:0]    pmem_addr,
    output logic                   pmem_rd_en,
    input  logic [INSTR_WIDTH-1:0] pmem_data,
    output logic [INSTR_WIDTH-1:0] instruction_out,
    output logic [PC_WIDTH-1:0]    return_addr_out,
    output logic                   take_branch_addr_out,
    output logic                   fetch_valid
);

    localparam logic [PC_WIDTH-1:0]    PC_ONE = PC_WIDTH'(1);
    localparam logic [INSTR_WIDTH-1:0] NOP_WORD = INSTR_WIDTH'(CPU_NOP);

    fetch_state_e          state_r;
    fetch_state_e          state_nx_s;
    logic [PC_WIDTH-1:0]   pc_r;
    logic [PC_WIDTH-1:0]   pc_nx_s;

    logic                  rd_en_s;
    logic [PC_WIDTH-1:0]   addr_s;
    logic                  issue_tgt_s;
    logic                  capture_s;
    logic                  clear_s;

    // Context of the read issued last cycle; the word itself arrives on
    // pmem_data and is paired with these registered side values.
    logic                  rd_issued_r;
    logic [PC_WIDTH-1:0]   ret_r;
    logic                  tgt_r;

    logic [INSTR_WIDTH-1:0] live_word_s;
    logic [PC_WIDTH-1:0]    live_ret_s;
    logic                   live_tgt_s;
    logic                   use_hold_s;

    // FSM state and program counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= FETCH_IDLE;
            pc_r    <= {PC_WIDTH{1'b0}};
        end else begin
            state_r <= state_nx_s;
            pc_r    <= pc_nx_s;
        end
    end

    // Next-state, next-pc and read-request decode. A redirect outranks a
    // stall; pc arithmetic wraps naturally at PC_WIDTH bits.
    always_comb begin
        state_nx_s  = state_r;
        pc_nx_s     = pc_r;
        rd_en_s     = 1'b0;
        addr_s      = pc_r;
        issue_tgt_s = 1'b0;
        capture_s   = 1'b0;
        clear_s     = 1'b0;
        if (reset) begin
            state_nx_s = FETCH_IDLE;
        end else begin
            case (state_r)
                FETCH_IDLE: begin
                    rd_en_s    = 1'b1;
                    addr_s     = pc_r;
                    pc_nx_s    = pc_r + PC_ONE;
                    state_nx_s = FETCH_RUN;
                end
                FETCH_RUN: begin
                    if (take_branch_addr) begin
                        rd_en_s     = 1'b1;
                        addr_s      = branch_addr;
                        pc_nx_s     = branch_addr + PC_ONE;
                        issue_tgt_s = 1'b1;
                        clear_s     = 1'b1;
                        state_nx_s  = FETCH_RUN;
                    end else if (stall) begin
                        capture_s  = 1'b1;
                        state_nx_s = FETCH_HOLD;
                    end else begin
                        rd_en_s    = 1'b1;
                        addr_s     = pc_r;
                        pc_nx_s    = pc_r + PC_ONE;
                        state_nx_s = FETCH_RUN;
                    end
                end
                FETCH_HOLD: begin
                    if (take_branch_addr) begin
                        rd_en_s     = 1'b1;
                        addr_s      = branch_addr;
                        pc_nx_s     = branch_addr + PC_ONE;
                        issue_tgt_s = 1'b1;
                        clear_s     = 1'b1;
                        state_nx_s  = FETCH_RUN;
                    end else if (stall) begin
                        state_nx_s = FETCH_HOLD;
                    end else begin
                        // Held word is still shown this cycle; the next
                        // word is requested now so it lands right after.
                        rd_en_s    = 1'b1;
                        addr_s     = pc_r;
                        pc_nx_s    = pc_r + PC_ONE;
                        state_nx_s = FETCH_RUN;
                    end
                end
                default: begin
                    state_nx_s = FETCH_IDLE;
                end
            endcase
        end
    end

    // Side information travelling alongside the outstanding read.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_issued_r <= 1'b0;
            ret_r       <= {PC_WIDTH{1'b0}};
            tgt_r       <= 1'b0;
        end else begin
            rd_issued_r <= rd_en_s;
            ret_r       <= addr_s + PC_ONE;
            tgt_r       <= issue_tgt_s;
        end
    end

    // Live path: returned word when a read is outstanding, otherwise a bubble.
    always_comb begin
        live_word_s = NOP_WORD;
        live_ret_s  = {PC_WIDTH{1'b0}};
        live_tgt_s  = 1'b0;
        if (rd_issued_r && !reset) begin
            live_word_s = pmem_data;
            live_ret_s  = ret_r;
            live_tgt_s  = tgt_r;
        end else begin
            live_word_s = NOP_WORD;
            live_ret_s  = {PC_WIDTH{1'b0}};
            live_tgt_s  = 1'b0;
        end
    end

    assign use_hold_s = (state_r == FETCH_HOLD) && !reset;

    fetch_hold_buffer #(
        .PC_WIDTH    (PC_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_hold (
        .clock     (clock),
        .reset     (reset),
        .capture   (capture_s),
        .clear     (clear_s),
        .use_hold  (use_hold_s),
        .live_word (live_word_s),
        .live_ret  (live_ret_s),
        .live_tgt  (live_tgt_s),
        .word_out  (instruction_out),
        .ret_out   (return_addr_out),
        .tgt_out   (take_branch_addr_out)
    );

    assign pmem_addr   = addr_s;
    assign pmem_rd_en  = rd_en_s;
    assign fetch_valid = !reset && (use_hold_s || rd_issued_r);

endmodule : instruction_fetch

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch with a one-cycle-latency
// program-memory model whose contents are mem[a] = 0xAAAA0001 + a.
module tb_instruction_fetch;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        take_branch_addr;
    logic [13:0] branch_addr;
    logic [13:0] pmem_addr;
    logic        pmem_rd_en;
    logic [31:0] pmem_data;
    logic [31:0] instruction_out;
    logic [13:0] return_addr_out;
    logic        take_branch_addr_out;
    logic        fetch_valid;

    int checks_cnt = 0;
    int errors_cnt = 0;

    instruction_fetch dut (
        .clock                (clock),
        .reset                (reset),
        .stall                (stall),
        .take_branch_addr     (take_branch_addr),
        .branch_addr          (branch_addr),
        .pmem_addr            (pmem_addr),
        .pmem_rd_en           (pmem_rd_en),
        .pmem_data            (pmem_data),
        .instruction_out      (instruction_out),
        .return_addr_out      (return_addr_out),
        .take_branch_addr_out (take_branch_addr_out),
        .fetch_valid          (fetch_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mem(input logic [13:0] a);
        return 32'hAAAA_0001 + {18'd0, a};
    endfunction

    // Memory answers one cycle after a strobe; garbage otherwise.
    initial pmem_data = 32'hDEAD_BEEF;
    always @(posedge clock) begin
        if (pmem_rd_en) pmem_data <= mem(pmem_addr);
        else            pmem_data <= 32'hDEAD_BEEF;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [31:0] w, input logic [13:0] ret,
                             input logic tgt, input logic vld);
        check_val({tag, "_instr"}, instruction_out, w);
        check_val({tag, "_ret"}, 32'(return_addr_out), 32'(ret));
        check_val({tag, "_tgt"}, 32'(take_branch_addr_out), 32'(tgt));
        check_val({tag, "_valid"}, 32'(fetch_valid), 32'(vld));
    endtask

    task automatic check_rd(input string tag, input logic en, input logic [13:0] a);
        check_val({tag, "_rd_en"}, 32'(pmem_rd_en), 32'(en));
        if (en) check_val({tag, "_addr"}, 32'(pmem_addr), 32'(a));
    endtask

    initial begin
        int budget;
        reset = 1'b1; stall = 1'b0; take_branch_addr = 1'b0; branch_addr = 14'd0;
        step(); step();
        #1;
        check_rd("in_reset", 1'b0, 14'd0);
        check_out("in_reset", 32'd0, 14'd0, 1'b0, 1'b0);

        // Reset release: consecutive reads 0,1,2.
        step(); reset = 1'b0; #1;
        check_rd("idle", 1'b1, 14'd0);
        check_out("idle", 32'd0, 14'd0, 1'b0, 1'b0);
        step(); #1;
        check_rd("run1", 1'b1, 14'd1);
        check_out("run1", 32'hAAAA_0001, 14'd1, 1'b0, 1'b1);
        step(); #1;
        check_rd("run2", 1'b1, 14'd2);
        check_out("run2", mem(14'd1), 14'd2, 1'b0, 1'b1);

        // Advance until mem[5] is on the output (read of 6 pending).
        repeat (4) step();
        #1;
        check_out("pre_stall", mem(14'd5), 14'd6, 1'b0, 1'b1);

        // Three-cycle stall.
        stall = 1'b1; #1;
        check_rd("stall0", 1'b0, 14'd0);
        check_out("stall0", mem(14'd5), 14'd6, 1'b0, 1'b1);
        for (int i = 1; i < 3; i++) begin
            step(); #1;
            check_rd("stall_hold", 1'b0, 14'd0);
            check_out("stall_hold", mem(14'd5), 14'd6, 1'b0, 1'b1);
        end
        step(); stall = 1'b0; #1;
        check_rd("release", 1'b1, 14'd6);
        check_out("release", mem(14'd5), 14'd6, 1'b0, 1'b1);
        step(); #1;
        check_rd("after_release", 1'b1, 14'd7);
        check_out("after_release", mem(14'd6), 14'd7, 1'b0, 1'b1);

        // Run to pc = 0x0020, then redirect to 0x0100.
        budget = 100;
        while (pmem_addr != 14'h0020 && budget > 0) begin
            step(); #1;
            budget--;
        end
        check_val("reach_0x20_budget", 32'(budget > 0), 32'd1);
        take_branch_addr = 1'b1; branch_addr = 14'h0100; #1;
        check_rd("redirect", 1'b1, 14'h0100);
        step(); take_branch_addr = 1'b0; #1;
        check_rd("redirect_next", 1'b1, 14'h0101);
        check_out("redirect_next", mem(14'h0100), 14'h0101, 1'b1, 1'b1);
        step(); #1;
        check_out("redirect_next2", mem(14'h0101), 14'h0102, 1'b0, 1'b1);

        // Enter HOLD, then stall and redirect together to 0x0040.
        stall = 1'b1; #1;
        step(); take_branch_addr = 1'b1; branch_addr = 14'h0040; #1;
        check_rd("stall_and_branch", 1'b1, 14'h0040);
        step(); take_branch_addr = 1'b0; stall = 1'b0; #1;
        check_out("stall_and_branch_next", mem(14'h0040), 14'h0041, 1'b1, 1'b1);
        check_rd("stall_and_branch_next", 1'b1, 14'h0041);

        // Wrap at the top of the address space.
        take_branch_addr = 1'b1; branch_addr = 14'h3FFF; #1;
        check_rd("wrap_branch", 1'b1, 14'h3FFF);
        step(); take_branch_addr = 1'b0; #1;
        check_out("wrap", mem(14'h3FFF), 14'h0000, 1'b1, 1'b1);
        check_rd("wrap", 1'b1, 14'h0000);
        step(); #1;
        check_out("wrap_next", mem(14'h0000), 14'h0001, 1'b0, 1'b1);

        // Reset asserted while in HOLD.
        stall = 1'b1; #1;
        step(); #1;
        check_rd("hold_before_reset", 1'b0, 14'd0);
        reset = 1'b1; #1;
        step(); #1;
        check_rd("reset_in_hold", 1'b0, 14'd0);
        check_out("reset_in_hold", 32'd0, 14'd0, 1'b0, 1'b0);
        reset = 1'b0; stall = 1'b0; #1;
        check_rd("restart", 1'b1, 14'd0);
        check_out("restart", 32'd0, 14'd0, 1'b0, 1'b0);
        step(); #1;
        check_rd("restart_next", 1'b1, 14'd1);
        check_out("restart_next", 32'hAAAA_0001, 14'd1, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule : tb_instruction_fetch
